sram_axil: RTL and testbench

AXI4-Lite memory responder: the slave end of the bus the core's fetch and load/store units drive as initiators. It is word-addressed SRAM with independent read and write channels. Per-transaction response latency is programmable: either a fixed value or pseudo-random from an internal LFSR, so initiator handshakes get exercised under back-pressure. It replaces the zero-latency combinational memory path and sits between the core's bus master ports and the backing store.

---
 rtl/sram_axil_pkg.sv | 19 +
 rtl/sram_axil_lat_lfsr.sv | 15 +
 rtl/sram_axil.sv | 171 +++++++++++++++++
 tb/tb_sram_axil.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axil_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
// Includes the latency LFSR step function.
package sram_axil_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feedback enters bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_axil_lat_lfsr.sv
// Free-running 8-bit LFSR that supplies pseudo-random response latencies.
module lat_lfsr
  import sram_axil_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LFSR_SEED;
    else        state <= lfsr_next(state);
  end

endmodule

// File: rtl/sram_axil.sv
// AXI4-Lite word-addressed SRAM responder with fixed or LFSR-drawn latency.
// Read and write channels run independent FSMs, one transaction each.
module sram_axil
  import sram_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int RAND_LAT = 0,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(64'd4 << DEPTH_LOG2);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [7:0]        lfsr;
  logic              lfsr_unused;

  rd_state_t         rd_state;
  logic [2:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr;

  wr_state_t         wr_state;
  logic [2:0]        wr_cnt;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;

  logic [2:0] rd_lat, wr_lat;
  logic       ar_hs, aw_hs, w_hs, wr_go, commit;

  lat_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .state(lfsr));

  // Addresses below BASE wrap to a huge offset, so one compare covers both ends.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  assign lfsr_unused = ^lfsr;
  assign rd_lat = (RAND_LAT != 0) ? lfsr[2:0] : 3'(RD_LAT);
  assign wr_lat = (RAND_LAT != 0) ? lfsr[5:3] : 3'(WR_LAT);

  // valid/ready: a beat transfers on the rising edge where both are high;
  // every ready and valid here decodes registered state only.
  assign arready = (rd_state == R_IDLE);
  assign rvalid  = (rd_state == R_RESP);
  assign awready = (wr_state == W_IDLE) && !aw_held;
  assign wready  = (wr_state == W_IDLE) && !w_held;
  assign bvalid  = (wr_state == W_RESP);

  assign ar_hs  = arvalid && arready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign wr_go  = (aw_held || aw_hs) && (w_held || w_hs);
  assign commit = (wr_state == W_WAIT) && (wr_cnt == 3'd0);

  // Counter holds L and the response leaves R_WAIT once it reaches zero,
  // giving rvalid L+1 edges after the address handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_addr  <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rd_addr  <= araddr;
          rd_cnt   <= rd_lat;
          rd_state <= R_WAIT;
        end
        R_WAIT: if (rd_cnt == 3'd0) begin
          rd_state <= R_RESP;
          if (in_range(rd_addr)) begin
            rdata <= mem[word_idx(rd_addr)];
            rresp <= RESP_OKAY;
          end else begin
            rdata <= '0;
            rresp <= RESP_SLVERR;
          end
        end else begin
          rd_cnt <= rd_cnt - 3'd1;
        end
        R_RESP: if (rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr <= awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
            w_held  <= 1'b1;
          end
          if (wr_go) begin
            wr_cnt   <= wr_lat;
            wr_state <= W_WAIT;
          end
        end
        W_WAIT: if (commit) begin
          bresp    <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
          wr_state <= W_RESP;
        end else begin
          wr_cnt <= wr_cnt - 3'd1;
        end
        W_RESP: if (bready) begin
          wr_state <= W_IDLE;
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Same-edge read sampling sees the old word because both use nonblocking updates.
  always_ff @(posedge clk) begin
    if (commit && in_range(wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_axil.sv
// Bench for sram_axil: three instances (zero latency, fixed 3/2, LFSR latency)
// driven serially and checked against an array model and a polynomial LFSR model.
module tb_sram_axil;

  localparam int ND = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr [ND], rdata [ND], awaddr [ND], wdata [ND];
  logic        arvalid [ND], arready [ND], rvalid [ND], rready [ND];
  logic        awvalid [ND], awready [ND], wvalid [ND], wready [ND];
  logic        bvalid [ND], bready [ND];
  logic [1:0]  rresp [ND], bresp [ND];
  logic [3:0]  wstrb [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sram_axil #(
      .RAND_LAT(g == 2 ? 1 : 0),
      .RD_LAT  (g == 1 ? 3 : 0),
      .WR_LAT  (g == 1 ? 2 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
      .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
      .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
      .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem_m [ND][16];
  logic [7:0]  lfsr_m;

  // Reference LFSR written straight from the polynomial x^8+x^6+x^5+x^4+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'h4000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic int exp_lat(input int d, input bit wr, input logic [7:0] l);
    if (d == 2) return wr ? int'(l[5:3]) : int'(l[2:0]);
    if (d == 1) return wr ? 2 : 3;
    return 0;
  endfunction

  task automatic do_read(input int d, input logic [31:0] addr, input int stall,
                         output logic [31:0] data);
    logic [7:0] ls;
    logic [1:0] exp_r;
    int e;
    bit bad;
    exp_q.push_back(in_rng(addr) ? mem_m[d][widx(addr)] : 32'h0);
    exp_r = in_rng(addr) ? 2'b00 : 2'b10;
    @(negedge clk);
    araddr[d] = addr; arvalid[d] = 1'b1; rready[d] = 1'b0;
    e = 0;
    while (!arready[d] && e < 20) begin @(negedge clk); e++; end
    ls = lfsr_m;
    @(negedge clk);
    arvalid[d] = 1'b0;
    e = 0;
    while (!rvalid[d] && e < 30) begin @(negedge clk); e++; end
    check("rd_lat", e - 1, exp_lat(d, 1'b0, ls));
    data = rdata[d];
    check("rdata", data, exp_q.pop_front());
    check("rresp", {30'd0, rresp[d]}, {30'd0, exp_r});
    bad = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if (rdata[d] !== data || rvalid[d] !== 1'b1 || arready[d] !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) check("r_hold", {31'd0, bad}, 32'd0);
    rready[d] = 1'b1;
    @(negedge clk);
    rready[d] = 1'b0;
    check("r_done", {30'd0, rvalid[d], arready[d]}, 32'd1);
  endtask

  // order: 0 = AW and W together, 1 = W leads by gap, 2 = AW leads by gap
  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order, input int gap, input int stall);
    logic [7:0] ls;
    logic [1:0] exp_r;
    int e, c, aw_at, w_at;
    bit aw_done, w_done, hs_aw, hs_w, bad;
    exp_r = in_rng(addr) ? 2'b00 : 2'b10;
    aw_at = (order == 1) ? gap : 0;
    w_at  = (order == 2) ? gap : 0;
    aw_done = 1'b0; w_done = 1'b0; hs_aw = 1'b0; hs_w = 1'b0; bad = 1'b0;
    ls = lfsr_m; c = 0;
    bready[d] = 1'b0;
    while (c < 40) begin
      @(negedge clk);
      if (hs_aw) begin awvalid[d] = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid[d]  = 1'b0; w_done  = 1'b1; end
      if (aw_done && w_done) break;
      if (!aw_done && c >= aw_at) begin awaddr[d] = addr; awvalid[d] = 1'b1; end
      if (!w_done && c >= w_at) begin
        wdata[d] = data; wstrb[d] = strb; wvalid[d] = 1'b1;
      end
      if (w_done && wready[d] !== 1'b0) bad = 1'b1;
      if (aw_done && awready[d] !== 1'b0) bad = 1'b1;
      hs_aw = awvalid[d] && awready[d];
      hs_w  = wvalid[d] && wready[d];
      if (hs_aw || hs_w) ls = lfsr_m;
      c++;
    end
    check("w_held_ready", {31'd0, bad}, 32'd0);
    e = 0;
    while (!bvalid[d] && e < 30) begin @(negedge clk); e++; end
    check("wr_lat", e - 1, exp_lat(d, 1'b1, ls));
    check("bresp", {30'd0, bresp[d]}, {30'd0, exp_r});
    repeat (stall) @(negedge clk);
    bready[d] = 1'b1;
    @(negedge clk);
    bready[d] = 1'b0;
    check("b_done", {29'd0, bvalid[d], awready[d], wready[d]}, 32'd3);
    if (in_rng(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[d][widx(addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    for (int d = 0; d < ND; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
      wvalid[d] = 1'b0; bready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_flags", {27'd0, arready[d], awready[d], wready[d], rvalid[d], bvalid[d]}, 32'h1C);
      check("rst_rdata", rdata[d], 32'h0);
      check("rst_resp", {28'd0, rresp[d], bresp[d]}, 32'h0);
    end
    rst_n = 1'b1;

    // Zero-latency instance: basic write/read, strobes, decode errors.
    do_write(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(0, BASE + 32'h10, 0, rd);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);
    do_write(0, BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 2, 1, 1);
    do_read(0, BASE + 32'h20, 0, rd);
    check("strobe_merge", rd, 32'h11BB_33DD);
    do_write(0, BASE, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    do_write(0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_read(0, BASE, 0, rd);
    check("oor_wr_no_effect", rd, 32'h0BAD_F00D);
    do_read(0, 32'h0000_0000, 0, rd);
    check("oor_rdata", rd, 32'h0);

    // Fixed RD_LAT=3 / WR_LAT=2: W leads AW, held read response.
    do_write(1, BASE + 32'h8, 32'h5A5A_1234, 4'hF, 1, 2, 0);
    do_read(1, BASE + 32'h8, 5, rd);
    check("lat3_data", rd, 32'h5A5A_1234);
    do_write(1, BASE + 32'h8, 32'h0000_9900, 4'b0010, 2, 1, 3);
    do_read(1, BASE + 32'h8, 1, rd);
    check("lat3_strobe", rd, 32'h5A5A_9934);

    // Reset while the write sits in W_WAIT must drop it.
    do_write(1, BASE + 32'h14, 32'hCAFE_0005, 4'hF, 0, 0, 0);
    @(negedge clk);
    awaddr[1] = BASE + 32'h14; awvalid[1] = 1'b1;
    wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
    @(negedge clk);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_bvalid", {31'd0, bvalid[1]}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_resp", {31'd0, bvalid[1]}, 32'd0);
    do_read(1, BASE + 32'h14, 0, rd);
    check("rst_no_commit", rd, 32'hCAFE_0005);

    // LFSR-latency instance: preload, then random traffic with stalls.
    for (int w = 0; w < 16; w++) do_write(2, BASE + 32'(w * 4), $urandom, 4'hF, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 15))
        0: a = $urandom & 32'h0000_0FFF;
        1: a = BASE + 32'h4000 + 32'($urandom_range(0, 1023));
        2: a = BASE - 32'd4;
        default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) do_read(2, a, $urandom_range(0, 3), rd);
      else do_write(2, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
